// File: rtl/spram_pkg.sv
// spram_pkg: shared types and helpers for the sized single-port data RAM.
//   sz_e        access size encoding (byte, half, word, dword)
//   state_e     sequencer states (zero-fill, ready)
//   lane_mask   byte-lane write mask for an access of size sz at offset off
//   extract_ext right-align a lane-packed word and sign/zero extend it
package spram_pkg;

  localparam int unsigned TILE_DW = 16;
  localparam int unsigned TILE_MW = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } sz_e;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // ((1 << 2^sz) - 1) << off, up to eight lanes
  function automatic logic [7:0] lane_mask(input sz_e sz, input logic [2:0] off);
    logic [7:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Shift the selected bytes down to bit 0, then extend from the access width
  function automatic logic [63:0] extract_ext(input logic [63:0] word, input logic [2:0] off,
                                              input sz_e sz, input logic sgn);
    logic [63:0] sh;
    logic [63:0] res;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_B:    res = {{56{sgn & sh[7]}}, sh[7:0]};
      SZ_H:    res = {{48{sgn & sh[15]}}, sh[15:0]};
      SZ_W:    res = {{32{sgn & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spram_tile.sv
// spram_tile: behavioural 2^AW x 16 single-port RAM, SP256K pin-compatible subset.
//   clk     clock
//   ad      word address
//   di      write data
//   maskwe  per-nibble write enable (bit n covers di[4n+3:4n])
//   we      1 = write, 0 = read (only while cs)
//   cs      chip select
//   dout    registered read data, write-first on a write cycle
module spram_tile
  import spram_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic                clk,
  input  logic [AW-1:0]       ad,
  input  logic [TILE_DW-1:0]  di,
  input  logic [TILE_MW-1:0]  maskwe,
  input  logic                we,
  input  logic                cs,
  output logic [TILE_DW-1:0]  dout
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [TILE_DW-1:0] mem [DEPTH];
  logic [TILE_DW-1:0] rd_c;
  logic [TILE_DW-1:0] merged_c;

  assign rd_c = mem[ad];

  // Nibble-masked merge of new data over the stored word
  for (genvar n = 0; n < TILE_MW; n++) begin : g_nib
    assign merged_c[4*n +: 4] = maskwe[n] ? di[4*n +: 4] : rd_c[4*n +: 4];
  end

  // Write-first: a write cycle also presents the merged word on dout
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        mem[ad] <= merged_c;
        dout    <= merged_c;
      end else begin
        dout    <= rd_c;
      end
    end
  end

endmodule

// File: rtl/spram_sized.sv
// spram_sized: parametrised single-port data RAM built from 16-bit tiles.
//   clk, rst  clock, synchronous active-high reset
//   req, rdy  request handshake (accepted when req & rdy)
//   we        1 = store, 0 = load
//   sz, sgn   access size (sz_e) and sign-extend flag for loads
//   ai        byte address
//   vi        store data, right-aligned
//   vo        load data, right-aligned and extended; held between rvalids
//   rvalid    one-cycle load response strobe
//   err       one-cycle strobe for a misaligned / oversized access
//   busy      zero-fill in progress
module spram_sized
  import spram_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned TILE_AW = 14,
  parameter int unsigned ROWS    = 2,
  parameter int unsigned INIT_EN = 1,
  parameter int unsigned AW      = $clog2(ROWS) + TILE_AW + $clog2(DW / 8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          rdy,
  input  logic          we,
  input  logic [1:0]    sz,
  input  logic          sgn,
  input  logic [AW-1:0] ai,
  input  logic [DW-1:0] vi,
  output logic [DW-1:0] vo,
  output logic          rvalid,
  output logic          err,
  output logic          busy
);

  localparam int unsigned LANES = DW / 8;
  localparam int unsigned OFFW  = $clog2(LANES);
  localparam int unsigned TPR   = DW / TILE_DW;
  localparam int unsigned WIW   = AW - OFFW;
  localparam int unsigned ROWW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e               state_q, state_d;
  logic [TILE_AW-1:0]   icnt_q, icnt_d;
  logic                 init_c, acc_c, acc_ok_c, legal_c;
  logic [OFFW-1:0]      off_c, algn_m_c;
  logic [WIW-1:0]       widx_c;
  logic [TILE_AW-1:0]   taddr_c;
  logic [ROWW-1:0]      row_c;
  logic [LANES-1:0]     lmask_c;
  logic [DW-1:0]        wdata_c, ext_c, vo_q;
  logic [ROWS-1:0][DW-1:0] row_word;
  logic [ROWW-1:0]      row_r;
  logic [OFFW-1:0]      off_r;
  sz_e                  sz_r;
  logic                 sgn_r;

  // State register; rdy/busy are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_EN != 0) ? INIT : IDLE;
      icnt_q  <= '0;
      rdy     <= (INIT_EN == 0);
      busy    <= (INIT_EN != 0);
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      rdy     <= (state_d == IDLE);
      busy    <= (state_d == INIT);
    end
  end

  // Next state: sweep every tile row once, then accept requests
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    case (state_q)
      INIT: begin
        icnt_d = icnt_q + TILE_AW'(1);
        if (icnt_q == '1) state_d = IDLE;
      end
      IDLE:    ;
      default: state_d = IDLE;
    endcase
  end

  // Outputs of the sequencer driving the tile array
  always_comb begin
    init_c = 1'b0;
    acc_c  = 1'b0;
    case (state_q)
      INIT:    init_c = 1'b1;
      IDLE:    acc_c  = req & ~rst;
      default: ;
    endcase
  end

  // Address split and alignment check
  assign off_c    = ai[OFFW-1:0];
  assign widx_c   = ai[AW-1:OFFW];
  assign taddr_c  = widx_c[TILE_AW-1:0];
  assign algn_m_c = OFFW'((32'd1 << sz) - 32'd1);
  assign legal_c  = (32'(sz) <= OFFW) && ((off_c & algn_m_c) == '0);
  assign acc_ok_c = acc_c & legal_c;
  assign lmask_c  = LANES'(lane_mask(sz_e'(sz), 3'(off_c)));

  if (ROWS > 1) begin : g_row_sel
    assign row_c = widx_c[WIW-1 -: ROWW];
  end else begin : g_row_one
    assign row_c = '0;
  end

  // Store data replicated so every lane the mask can pick holds the value
  always_comb begin
    case (sz_e'(sz))
      SZ_B:    wdata_c = {(DW / 8){vi[7:0]}};
      SZ_H:    wdata_c = {(DW / 16){vi[15:0]}};
      SZ_W:    wdata_c = {(DW / 32){vi[31:0]}};
      default: wdata_c = vi;
    endcase
  end

  // Tile array: zero-fill broadside during INIT, otherwise one row selected
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar t = 0; t < TPR; t++) begin : g_tile
      spram_tile #(.AW(TILE_AW)) u_tile (
        .clk    (clk),
        .ad     (init_c ? icnt_q : taddr_c),
        .di     (init_c ? 16'h0000 : wdata_c[TILE_DW*t +: TILE_DW]),
        .maskwe (init_c ? 4'hF : {lmask_c[2*t+1], lmask_c[2*t+1], lmask_c[2*t], lmask_c[2*t]}),
        .we     (init_c | we),
        .cs     (init_c | (acc_ok_c && (row_c == ROWW'(r)))),
        .dout   (row_word[r][TILE_DW*t +: TILE_DW])
      );
    end
  end

  // Load result is formed from the tile output register; vo_q holds it afterwards
  assign ext_c = DW'(extract_ext(64'(row_word[row_r]), 3'(off_r), sz_r, sgn_r));
  assign vo    = rvalid ? ext_c : vo_q;

  // Response strobes and load context captured at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      vo_q   <= '0;
      row_r  <= '0;
      off_r  <= '0;
      sz_r   <= SZ_B;
      sgn_r  <= 1'b0;
    end else begin
      rvalid <= acc_ok_c & ~we;
      err    <= acc_c & ~legal_c;
      if (acc_ok_c && !we) begin
        row_r <= row_c;
        off_r <= off_c;
        sz_r  <= sz_e'(sz);
        sgn_r <= sgn;
      end
      if (rvalid) vo_q <= ext_c;
    end
  end

endmodule

// File: doc/spram_sized.md
# spram_sized

Parametrised single-port RAM for eJ32 data memory, replacing the fixed 32K×32 / byte-debug pair. It is built from 16-bit-wide tiles with a nibble write mask and has one request port. The port accepts byte, half, word and (when DW=64) dword accesses, with sign or zero extension on loads and misalignment detection. After reset, an internal sequencer zero-fills the whole array before the first request is accepted.

## Interface
Parameters:
- DW, 32: data width; 32 or 64 only.
- TILE_AW, 14: address width of one 16-bit tile (16K deep, SP256K-sized).
- ROWS, 2: tiles stacked in depth. Total words = ROWS·2^TILE_AW.
- INIT_EN, 1: 1 enables the zero-fill after reset; 0 starts in IDLE.
- AW, derived: byte-address width = log2(ROWS) + TILE_AW + log2(DW/8).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- req, in, 1: access request.
- rdy, out, 1: request accepted this cycle when req&rdy.
- we, in, 1: 1 = store, 0 = load.
- sz, in, 2: 0 byte, 1 half, 2 word, 3 dword. A dword access with DW=32 is an error.
- sgn, in, 1: sign-extend the load result.
- ai, in, AW: byte address.
- vi, in, DW: store data, right-aligned.
- vo, out, DW: load data, right-aligned and extended.
- rvalid, out, 1: vo valid, single-cycle pulse.
- err, out, 1: misaligned or illegal access, single-cycle pulse.
- busy, out, 1: init in progress.

## Operation
- FSM states: INIT, IDLE.
- rst enters INIT if INIT_EN, otherwise IDLE.
- **INIT**
  - Counter icnt runs 0 … 2^TILE_AW−1.
  - Each cycle, every tile is written with zero at row icnt, all masks enabled and all CS asserted.
  - After the last row the FSM moves to IDLE.
  - busy=1 and rdy=0 throughout INIT.
- **IDLE**
  - rdy=1 and busy=0.
- **Address split**
  - off = ai[log2(DW/8)−1:0].
  - word index = ai[AW−1:log2(DW/8)].
  - row = upper log2(ROWS) bits of the word index.
  - tile address = lower TILE_AW bits of the word index.
- **Alignment**
  - An access is legal iff off is a multiple of 2^sz and 2^sz ≤ DW/8.
  - An illegal access gives: no write, no rvalid, err=1 on the next cycle.
- **Store**
  - The lane byte mask is ((1<<2^sz)−1) << off.
  - Data is replicated across lanes: vi[8·2^sz−1:0] is repeated DW/(8·2^sz) times.
  - Each tile's 4-bit nibble mask is its two byte-mask bits, each doubled.
  - Only the selected row has CS asserted.
- **Load**
  - Tiles are read at the tile address. Row, off, sz and sgn are registered at acceptance.
  - On the next cycle the selected row's word is shifted right by 8·off_r and truncated to 8·2^sz_r bits.
  - It is then sign-extended if sgn_r, otherwise zero-extended, to DW.
- Stores produce no response.

## Timing
- Reset values: rdy=0 (1 if INIT_EN=0), busy=INIT_EN, rvalid=0, err=0, vo=0.
- Init length is exactly 2^TILE_AW cycles. rdy rises on the cycle after the last init write.
- Load latency is 1: accept at cycle N gives rvalid and vo at N+1.
- vo holds its value until the next rvalid.
- Back-to-back loads are allowed every cycle, at full throughput.
- A load following a store to the same address on the next cycle returns the new data; tile write-first behaviour is required.
- rst asserted mid-init restarts icnt at 0.
- rst during a pending load suppresses that rvalid.
- req while rdy=0 is ignored; the requester holds req.

## Structure
- Package spram_pkg holds:
  - the sz_e enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the state_e enum (INIT, IDLE);
  - a function for lane mask generation;
  - a function for extract-and-extend.
- Sub-module spram_tile: a behavioural 2^TILE_AW×16 RAM with 4-bit nibble mask, WE and CS, 1-cycle registered DO, pin-compatible with SP256K. It is instantiated (DW/16)·ROWS times by a generate loop.

## Test plan
Bench parameters: DW=32, TILE_AW=5, ROWS=2, INIT_EN=1.

1. **Init:** release rst, then busy=1 for exactly 32 cycles and rdy=1 at cycle 33. A load of word at 0x7C gives vo=0.
2. **Word:** store word 0xDEADBEEF at 0x40, load word 0x40 → rvalid at +1, vo=0xDEADBEEF.
3. **Byte/half extension:**
   - store byte 0x80 at 0x41;
   - load byte at 0x41 with sgn=1 → 0xFFFFFF80; with sgn=0 → 0x00000080;
   - load half at 0x42 → 0x0000DEAD.
4. **Misalignment:** half at 0x43, word at 0x42, and dword anywhere each give err=1 at +1 with no rvalid. A follow-up load of 0x40 is unchanged.
5. **Row select and back-to-back:**
   - store 0x11111111 at 0x00 and 0x22222222 at 0x80;
   - loads of 0x00 and 0x80 on consecutive cycles give 0x11111111 then 0x22222222 on consecutive rvalids.
6. **Reset mid-init:** assert rst at init cycle 10, then busy lasts 32 more cycles after release, and the previously written 0x40 reads 0.
